// File: rtl/load_store_ctrl.sv
// Load/store controller: aligns, checks and issues one memory access at a time,
// then returns the extended load result or an error pulse.
module load_store_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_option,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [2:0] OPT_W  = 3'b000;
  localparam logic [2:0] OPT_HS = 3'b001;
  localparam logic [2:0] OPT_HU = 3'b010;
  localparam logic [2:0] OPT_BS = 3'b011;
  localparam logic [2:0] OPT_BU = 3'b100;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  opt_q, opt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  function automatic logic acc_err(
    input logic [2:0] opt,
    input logic [1:0] off
  );
    logic e;
    case (opt)
      OPT_W:          e = (off != 2'b00);
      OPT_HS, OPT_HU: e = off[0];
      OPT_BS, OPT_BU: e = 1'b0;
      default:        e = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [3:0] acc_be(
    input logic [2:0] opt,
    input logic [1:0] off
  );
    logic [3:0] be;
    case (opt)
      OPT_W:          be = 4'b1111;
      OPT_HS, OPT_HU: be = 4'b0011 << off;
      default:        be = 4'b0001 << off;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] acc_wdata(
    input logic [2:0]  opt,
    input logic [31:0] wd
  );
    logic [31:0] r;
    case (opt)
      OPT_W:          r = wd;
      OPT_HS, OPT_HU: r = {2{wd[15:0]}};
      default:        r = {4{wd[7:0]}};
    endcase
    return r;
  endfunction

  // Shift the addressed lane down to bit 0, then extend to 32 bits.
  function automatic logic [31:0] ld_ext(
    input logic [2:0]  opt,
    input logic [1:0]  off,
    input logic [31:0] rd
  );
    logic [31:0] sh;
    logic [31:0] r;
    sh = rd >> {off, 3'b000};
    case (opt)
      OPT_W:   r = sh;
      OPT_HS:  r = {{16{sh[15]}}, sh[15:0]};
      OPT_HU:  r = {16'h0000, sh[15:0]};
      OPT_BS:  r = {{24{sh[7]}}, sh[7:0]};
      OPT_BU:  r = {24'h000000, sh[7:0]};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      opt_q      <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      rsp_data_q <= 32'h0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      opt_q      <= opt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    opt_d      = opt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    unique case (state_q)
      S_IDLE: begin
        rsp_err_d  = 1'b0;
        rsp_data_d = 32'h0;
        if (req_valid) begin
          we_d    = req_we;
          opt_d   = req_option;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (acc_err(req_option, req_addr[1:0])) begin
            rsp_err_d = 1'b1;
            state_d   = S_RESP;
          end else begin
            state_d   = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (mem_ready) begin
          state_d = we_q ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          rsp_data_d = ld_ext(opt_q, addr_q[1:0], mem_rdata);
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign mem_valid = (state_q == S_ISSUE);
  assign mem_we    = (state_q == S_ISSUE) && we_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_be    = acc_be(opt_q, addr_q[1:0]);
  assign mem_wdata = acc_wdata(opt_q, wdata_q);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule
